ex_stage: RTL and testbench

Execute stage of the five-stage RV32I pipeline, between ID and MEM. It captures the ID-to-EX bus into a stall- and flush-aware pipeline register and resolves operands by forwarding from MEM and WB. It computes the ALU result, branch/jump target and link value, issues the data-SRAM request, and drives the redirect (`br_e`/`br_addr`) back to IF/ID.

---
 rtl/ex_stage_pkg.sv | 83 ++++++++
 rtl/ex_stage_alu.sv | 30 +++
 rtl/ex_stage.sv | 126 ++++++++++++
 tb/tb_ex_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the ID/EX/MEM stages: bus widths, one-hot op bit indices,
// selector encodings and the packed layouts of the stage-to-stage buses.
package ex_stage_pkg;

    localparam int ID2EX_W  = 205;
    localparam int EX2MEM_W = 112;
    localparam int FWD_W    = 38;

    localparam int ALU_ADD  = 9;
    localparam int ALU_SUB  = 8;
    localparam int ALU_SLT  = 7;
    localparam int ALU_SLTU = 6;
    localparam int ALU_AND  = 5;
    localparam int ALU_OR   = 4;
    localparam int ALU_XOR  = 3;
    localparam int ALU_SLL  = 2;
    localparam int ALU_SRL  = 1;
    localparam int ALU_SRA  = 0;

    localparam int BRU_BEQ  = 7;
    localparam int BRU_BNE  = 6;
    localparam int BRU_BLT  = 5;
    localparam int BRU_BGE  = 4;
    localparam int BRU_BLTU = 3;
    localparam int BRU_BGEU = 2;
    localparam int BRU_JAL  = 1;
    localparam int BRU_JALR = 0;

    localparam int LSU_LOAD  = 0;
    localparam int LSU_STORE = 1;
    localparam int LSU_BYTE  = 2;
    localparam int LSU_HALF  = 3;
    localparam int LSU_WORD  = 4;
    localparam int LSU_UNS   = 5;

    typedef enum logic [1:0] {SRC1_RS1 = 2'b00, SRC1_PC = 2'b01, SRC1_ZERO = 2'b10} src1_sel_e;
    typedef enum logic [1:0] {RES_ALU = 2'b00, RES_LINK = 2'b01, RES_LOAD = 2'b10} rf_res_sel_e;

    typedef struct packed {
        logic [1:0]  sel_src1;
        logic        sel_src2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [9:0]  alu_op;
        logic [7:0]  bru_op;
        logic [5:0]  lsu_op;
        logic [1:0]  sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] pc;
        logic [31:0] inst;
    } id2ex_t;

    typedef struct packed {
        logic [5:0]  lsu_op;
        logic [1:0]  sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
        logic [1:0]  addr_lo;
        logic [31:0] pc;
        logic [31:0] inst;
    } ex2mem_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } fwd_t;

    // MEM is younger than WB, so it wins when both write the same register.
    function automatic logic [31:0] fwd_pick(input logic [4:0] rs, input logic [31:0] stored,
                                             input fwd_t mem, input fwd_t wb);
        if (rs == 5'd0)                   return '0;
        if (mem.we && (mem.waddr == rs))  return mem.wdata;
        if (wb.we && (wb.waddr == rs))    return wb.wdata;
        return stored;
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU driven by a one-hot operation vector; all-zero op gives 0.
module alu
    import ex_stage_pkg::*;
(
    input  logic [9:0]  alu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);

    logic [4:0]  shamt;
    logic [31:0] sra_res;

    assign shamt   = src2[4:0];
    assign sra_res = $signed(src1) >>> shamt;

    always_comb begin
        result = ({32{alu_op[ALU_ADD]}}  & (src1 + src2))
               | ({32{alu_op[ALU_SUB]}}  & (src1 - src2))
               | ({32{alu_op[ALU_SLT]}}  & {31'b0, $signed(src1) < $signed(src2)})
               | ({32{alu_op[ALU_SLTU]}} & {31'b0, src1 < src2})
               | ({32{alu_op[ALU_AND]}}  & (src1 & src2))
               | ({32{alu_op[ALU_OR]}}   & (src1 | src2))
               | ({32{alu_op[ALU_XOR]}}  & (src1 ^ src2))
               | ({32{alu_op[ALU_SLL]}}  & (src1 << shamt))
               | ({32{alu_op[ALU_SRL]}}  & (src1 >> shamt))
               | ({32{alu_op[ALU_SRA]}}  & sra_res);
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ID/EX pipeline register, MEM/WB forwarding, ALU, branch
// resolution with IF/ID redirect, and data-SRAM request generation.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int ID2EX_WD  = ID2EX_W,
    parameter int EX2MEM_WD = EX2MEM_W,
    parameter int FWD_WD    = FWD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           stall,
    input  logic [ID2EX_WD-1:0]  id2ex_bus,
    input  logic [FWD_WD-1:0]    mem_fwd_bus,
    input  logic [FWD_WD-1:0]    wb_fwd_bus,
    output logic                 br_e,
    output logic [31:0]          br_addr,
    output logic                 data_sram_en,
    output logic [3:0]           data_sram_we,
    output logic [31:0]          data_sram_addr,
    output logic [31:0]          data_sram_wdata,
    output logic [EX2MEM_WD-1:0] ex2mem_bus
);

    id2ex_t      r;
    fwd_t        mem_fwd, wb_fwd;
    ex2mem_t     out;
    logic        valid, taken, ls_go, unused_stall;
    logic [31:0] rs1_val, rs2_val, src1, src2, alu_res, mem_addr, target, st_data;
    logic [3:0]  st_mask;

    assign unused_stall = ^{stall[5:4], stall[1:0]};
    assign mem_fwd      = fwd_t'(mem_fwd_bus);
    assign wb_fwd       = fwd_t'(wb_fwd_bus);

    // While EX holds, resolved operands are written back so a producer retiring
    // from WB during the stall is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r <= '0;
        else if (stall[2] && !stall[3]) r <= '0;
        else if (!stall[2] && br_e)    r <= '0;
        else if (!stall[2])            r <= id2ex_t'(id2ex_bus);
        else begin
            r.rdata1 <= rs1_val;
            r.rdata2 <= rs2_val;
        end
    end

    assign valid   = |r.inst;
    assign rs1_val = fwd_pick(r.rs1, r.rdata1, mem_fwd, wb_fwd);
    assign rs2_val = fwd_pick(r.rs2, r.rdata2, mem_fwd, wb_fwd);

    always_comb begin
        case (r.sel_src1)
            SRC1_RS1: src1 = rs1_val;
            SRC1_PC:  src1 = r.pc;
            default:  src1 = '0;
        endcase
    end

    assign src2 = r.sel_src2 ? r.imm : rs2_val;

    alu u_alu (
        .alu_op (r.alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (alu_res)
    );

    assign mem_addr = rs1_val + r.imm;

    always_comb begin
        taken = (r.bru_op[BRU_BEQ]  & (rs1_val == rs2_val))
              | (r.bru_op[BRU_BNE]  & (rs1_val != rs2_val))
              | (r.bru_op[BRU_BLT]  & ($signed(rs1_val) <  $signed(rs2_val)))
              | (r.bru_op[BRU_BGE]  & ($signed(rs1_val) >= $signed(rs2_val)))
              | (r.bru_op[BRU_BLTU] & (rs1_val <  rs2_val))
              | (r.bru_op[BRU_BGEU] & (rs1_val >= rs2_val))
              | r.bru_op[BRU_JAL] | r.bru_op[BRU_JALR];
    end

    // jalr target shares the rs1+imm adder with the load/store address.
    assign target  = r.bru_op[BRU_JALR] ? {mem_addr[31:1], 1'b0} : r.pc + r.imm;
    assign br_e    = valid & taken & ~stall[3];
    assign br_addr = br_e ? target : '0;

    always_comb begin
        if (r.lsu_op[LSU_BYTE]) begin
            st_data = {4{rs2_val[7:0]}};
            st_mask = 4'b0001 << mem_addr[1:0];
        end else if (r.lsu_op[LSU_HALF]) begin
            st_data = {2{rs2_val[15:0]}};
            st_mask = 4'b0011 << mem_addr[1:0];
        end else begin
            st_data = rs2_val;
            st_mask = 4'b1111;
        end
    end

    assign ls_go           = valid & (r.lsu_op[LSU_LOAD] | r.lsu_op[LSU_STORE]) & ~stall[3];
    assign data_sram_en    = ls_go;
    assign data_sram_we    = (ls_go & r.lsu_op[LSU_STORE]) ? st_mask : '0;
    assign data_sram_addr  = valid ? mem_addr : '0;
    assign data_sram_wdata = valid ? st_data : '0;

    always_comb begin
        out = '0;
        if (valid) begin
            out.lsu_op     = r.lsu_op;
            out.sel_rf_res = r.sel_rf_res;
            out.rf_we      = r.rf_we;
            out.rf_waddr   = r.rf_waddr;
            case (r.sel_rf_res)
                RES_LINK: out.ex_result = r.pc + 32'd4;
                RES_LOAD: out.ex_result = mem_addr;
                default:  out.ex_result = alu_res;
            endcase
            out.addr_lo    = mem_addr[1:0];
            out.pc         = r.pc;
            out.inst       = r.inst;
        end
    end

    assign ex2mem_bus = out;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus random stimulus against
// a behavioural model of the EX stage contents and its outputs.
module tb_ex_stage;

    typedef struct packed {
        logic [1:0]  sel_src1;
        logic        sel_src2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [9:0]  alu_op;
        logic [7:0]  bru_op;
        logic [5:0]  lsu_op;
        logic [1:0]  sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] pc;
        logic [31:0] inst;
    } id_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    stall;
    id_t           id_in;
    logic [204:0]  id2ex_bus;
    logic [37:0]   mem_fwd, wb_fwd;
    logic          br_e, data_sram_en;
    logic [31:0]   br_addr, data_sram_addr, data_sram_wdata;
    logic [3:0]    data_sram_we;
    logic [111:0]  ex2mem_bus;

    always #5 clk = ~clk;
    assign id2ex_bus = id_in;

    ex_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .id2ex_bus       (id2ex_bus),
        .mem_fwd_bus     (mem_fwd),
        .wb_fwd_bus      (wb_fwd),
        .br_e            (br_e),
        .br_addr         (br_addr),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .ex2mem_bus      (ex2mem_bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [111:0] got, input logic [111:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Model: the instruction the spec says should sit in EX, plus expected outputs.
    id_t          m;
    logic         e_br, e_en;
    logic [31:0]  e_baddr, e_addr, e_wdata, e_a, e_b;
    logic [3:0]   e_we;
    logic [111:0] e_bus;

    function automatic logic [31:0] opnd(input logic [4:0] rs, input logic [31:0] stored);
        if (rs == 0) return 0;
        if (mem_fwd[37] && mem_fwd[36:32] == rs) return mem_fwd[31:0];
        if (wb_fwd[37] && wb_fwd[36:32] == rs) return wb_fwd[31:0];
        return stored;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [9:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            10'h200: return x + y;
            10'h100: return x - y;
            10'h080: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            10'h040: return (x < y) ? 32'd1 : 32'd0;
            10'h020: return x & y;
            10'h010: return x | y;
            10'h008: return x ^ y;
            10'h004: return x << y[4:0];
            10'h002: return x >> y[4:0];
            10'h001: return 32'($signed(x) >>> y[4:0]);
            default: return 0;
        endcase
    endfunction

    function automatic logic taken_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            8'h80: return a == b;
            8'h40: return a != b;
            8'h20: return $signed(a) < $signed(b);
            8'h10: return $signed(a) >= $signed(b);
            8'h08: return a < b;
            8'h04: return a >= b;
            8'h02, 8'h01: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic calc();
        logic        v, st;
        logic [31:0] s1, s2, addr, res;
        v    = (m.inst != 0);
        e_a  = opnd(m.rs1, m.rdata1);
        e_b  = opnd(m.rs2, m.rdata2);
        s1   = (m.sel_src1 == 2'd0) ? e_a : (m.sel_src1 == 2'd1) ? m.pc : 32'd0;
        s2   = m.sel_src2 ? m.imm : e_b;
        addr = e_a + m.imm;
        res  = (m.sel_rf_res == 2'd1) ? m.pc + 4 : (m.sel_rf_res == 2'd2) ? addr : alu_ref(m.alu_op, s1, s2);
        e_br    = v && taken_ref(m.bru_op, e_a, e_b) && !stall[3];
        e_baddr = (m.bru_op == 8'h01) ? ((e_a + m.imm) & ~32'd1) : m.pc + m.imm;
        e_en    = v && (m.lsu_op[0] || m.lsu_op[1]) && !stall[3];
        e_addr  = v ? addr : 0;
        st      = m.lsu_op[1];
        if (m.lsu_op[2])      begin e_wdata = {4{e_b[7:0]}};  e_we = 4'b0001 << addr[1:0]; end
        else if (m.lsu_op[3]) begin e_wdata = {2{e_b[15:0]}}; e_we = 4'b0011 << addr[1:0]; end
        else                  begin e_wdata = e_b;            e_we = 4'b1111;              end
        if (!(e_en && st)) e_we = 0;
        e_bus = v ? {m.lsu_op, m.sel_rf_res, m.rf_we, m.rf_waddr, res, addr[1:0], m.pc, m.inst} : '0;
    endtask

    task automatic cmp_all(input string tag);
        calc();
        check({tag, ".br_e"}, br_e, e_br);
        if (e_br) check({tag, ".br_addr"}, br_addr, e_baddr);
        check({tag, ".en"}, data_sram_en, e_en);
        check({tag, ".we"}, data_sram_we, e_we);
        check({tag, ".addr"}, data_sram_addr, e_addr);
        if (m.inst != 0 && m.lsu_op[1]) check({tag, ".wdata"}, data_sram_wdata, e_wdata);
        check({tag, ".bus"}, ex2mem_bus, e_bus);
    endtask

    task automatic edge_step();
        calc();
        if (stall[2] && !stall[3])     m = '0;
        else if (!stall[2] && e_br)    m = '0;
        else if (!stall[2])            m = id_in;
        else begin m.rdata1 = e_a; m.rdata2 = e_b; end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input id_t t);
        id_in = t;
        edge_step();
    endtask

    task automatic rand_inputs();
        id_t t;
        int  k;
        t = '0;
        if ($urandom_range(0, 6) != 0) begin
            t.sel_src1 = 2'($urandom_range(0, 2));
            t.sel_src2 = 1'($urandom_range(0, 1));
            t.rs1      = 5'($urandom_range(0, 7));
            t.rs2      = 5'($urandom_range(0, 7));
            t.rdata1   = $urandom;
            t.rdata2   = $urandom_range(0, 1) ? t.rdata1 : $urandom;
            t.imm      = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 64));
            k = $urandom_range(0, 10);
            t.alu_op   = (k == 10) ? 10'd0 : 10'(1 << k);
            k = $urandom_range(0, 11);
            t.bru_op   = (k < 8) ? 8'(1 << k) : 8'd0;
            k = $urandom_range(0, 2);
            if (k == 1) t.lsu_op = {1'($urandom_range(0, 1)), 3'(1 << $urandom_range(0, 2)), 2'b01};
            if (k == 2) t.lsu_op = {1'b0, 3'(1 << $urandom_range(0, 2)), 2'b10};
            t.sel_rf_res = (k == 1) ? 2'd2 : 2'($urandom_range(0, 1));
            t.rf_we    = 1'($urandom_range(0, 1));
            t.rf_waddr = 5'($urandom_range(0, 31));
            t.pc       = $urandom & 32'hffff_fffc;
            t.inst     = $urandom | 32'd1;
        end
        id_in   = t;
        mem_fwd = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom)};
        wb_fwd  = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom)};
        k = $urandom_range(0, 9);
        stall = {2'($urandom_range(0, 3)), (k < 6) ? 2'b00 : (k < 8) ? 2'b11 : (k == 8) ? 2'b01 : 2'b10,
                 2'($urandom_range(0, 3))};
    endtask

    id_t t, a2;

    initial begin
        rst_n = 0; stall = 0; id_in = '0; mem_fwd = '0; wb_fwd = '0; m = '0;
        #2;
        check("rst.br_e", br_e, 0);
        check("rst.en", data_sram_en, 0);
        check("rst.we", data_sram_we, 0);
        check("rst.wdata", data_sram_wdata, 0);
        check("rst.bus", ex2mem_bus, 0);
        #6 rst_n = 1;
        edge_step();
        cmp_all("idle");

        // add x3,x1,x2
        a2 = '0; a2.rs1 = 1; a2.rs2 = 2; a2.rdata1 = 5; a2.rdata2 = 7; a2.alu_op = 10'h200;
        a2.rf_we = 1; a2.rf_waddr = 3; a2.pc = 32'h80; a2.inst = 32'h002081b3;
        load(a2); id_in = '0; #1;
        check("add.res", ex2mem_bus[97:66], 12);
        check("add.rd", ex2mem_bus[102:98], 3);
        check("add.en", data_sram_en, 0);
        cmp_all("add");

        // forwarding priority
        t = '0; t.rs1 = 4; t.sel_src2 = 1; t.rdata1 = 32'hdead; t.alu_op = 10'h200; t.inst = 32'h13;
        load(t); id_in = '0;
        mem_fwd = {1'b1, 5'd4, 32'h10}; wb_fwd = {1'b1, 5'd4, 32'h20}; #1;
        check("fwd.mem", ex2mem_bus[97:66], 32'h10);
        mem_fwd[37] = 0; #1;
        check("fwd.wb", ex2mem_bus[97:66], 32'h20);
        t.rs1 = 0; load(t); id_in = '0;
        mem_fwd = {1'b1, 5'd0, 32'h10}; wb_fwd = {1'b1, 5'd0, 32'h20}; #1;
        check("fwd.x0", ex2mem_bus[97:66], 0);
        cmp_all("fwd");
        mem_fwd = '0; wb_fwd = '0;

        // taken beq, then wrong-path squash
        t = '0; t.rs1 = 1; t.rs2 = 2; t.rdata1 = 9; t.rdata2 = 9; t.bru_op = 8'h80;
        t.pc = 32'h100; t.imm = 32'h40; t.inst = 32'h04208063;
        load(t); id_in = a2; #1;
        check("beq.br_e", br_e, 1);
        check("beq.br_addr", br_addr, 32'h140);
        cmp_all("beq");
        edge_step();
        check("beq.once", br_e, 0);
        check("beq.squash", ex2mem_bus, 0);

        // jalr
        t = '0; t.rs1 = 5; t.rdata1 = 32'h203; t.bru_op = 8'h01; t.sel_rf_res = 2'b01;
        t.pc = 32'h300; t.rf_we = 1; t.rf_waddr = 1; t.inst = 32'h000280e7;
        load(t); id_in = '0; #1;
        check("jalr.br_e", br_e, 1);
        check("jalr.br_addr", br_addr, 32'h202);
        check("jalr.link", ex2mem_bus[97:66], 32'h304);
        cmp_all("jalr");
        edge_step();

        // sb
        t = '0; t.rs1 = 1; t.rs2 = 2; t.rdata1 = 32'h1001; t.rdata2 = 32'hab; t.lsu_op = 6'b000110;
        t.sel_src2 = 1; t.alu_op = 10'h200; t.inst = 32'h00208023;
        load(t); id_in = '0; #1;
        check("sb.en", data_sram_en, 1);
        check("sb.we", data_sram_we, 4'b0010);
        check("sb.wdata", data_sram_wdata, 32'habababab);
        check("sb.addr", data_sram_addr, 32'h1001);
        cmp_all("sb");

        // sw held 3 cycles, WB produces rs2 mid-stall
        t = '0; t.rs1 = 1; t.rs2 = 6; t.rdata1 = 32'h40; t.rdata2 = 32'h11; t.lsu_op = 6'b010010;
        t.sel_src2 = 1; t.alu_op = 10'h200; t.inst = 32'h0060a023;
        load(t); id_in = a2; stall = 6'b001100;
        for (int c = 0; c < 3; c++) begin
            wb_fwd = (c == 1) ? {1'b1, 5'd6, 32'h77} : '0;
            #1;
            check("hold.en", data_sram_en, 0);
            check("hold.br_e", br_e, 0);
            cmp_all("hold");
            edge_step();
        end
        stall = 0; wb_fwd = '0; #1;
        check("hold.rel_en", data_sram_en, 1);
        check("hold.refresh", data_sram_wdata, 32'h77);
        check("hold.we", data_sram_we, 4'hf);
        cmp_all("rel");

        // stall[2] only: bubble enters EX
        stall = 6'b000100;
        edge_step();
        check("s2.bubble", ex2mem_bus, 0);
        cmp_all("s2");
        stall = 0;

        // reset while held
        load(a2); stall = 6'b001100;
        edge_step();
        #2 rst_n = 0; #1;
        m = '0;
        check("rstmid.bus", ex2mem_bus, 0);
        check("rstmid.en", data_sram_en, 0);
        check("rstmid.addr", data_sram_addr, 0);
        cmp_all("rstmid");
        #2 rst_n = 1; stall = 0;
        edge_step();

        repeat (400) begin
            rand_inputs();
            #1;
            cmp_all("rnd");
            edge_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
